cpu_ctrl_seq: RTL and testbench

- Multi-cycle control sequencer for the 16-bit-instruction / 8-bit-datapath CPU.
- Fetches each instruction over a req/ready handshake, latches it into the instruction register, and decodes it.
- Drives the datapath control strobes: PC update, ALU op, register-file write and writeback select, data-memory access.
- Adds a data-memory timeout, a halt state, an illegal-opcode trap and a retired-instruction counter.

---
 rtl/cpu_ctrl_seq_if.sv | 28 ++
 rtl/cpu_ctrl_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_cpu_ctrl_seq.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_seq_if.sv
// Fetch and data-memory handshake bundle for the control sequencer.
// The sequencer is the bus master on both ports.
interface cpu_ctrl_seq_if;
    logic        imem_req;
    logic        imem_ready;
    logic [15:0] instr;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  instr,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output instr,
        output dmem_ready
    );
endinterface

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle control sequencer: fetch, decode, exec, mem, writeback,
// with data-memory timeout, illegal-opcode trap and retire counter.
module cpu_ctrl_seq #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    cpu_ctrl_seq_if.master   bus,
    output logic [15:0]      ir,
    output logic             pc_inc,
    output logic             pc_load,
    output logic [2:0]       alu_op,
    output logic             rf_we,
    output logic [1:0]       rf_wsel,
    input  logic             zero_flag,
    output logic             halted,
    output logic [1:0]       fault,
    output logic [2:0]       state_dbg,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_IMM  = 2'd1;
    localparam logic [1:0] WB_MEM  = 2'd2;
    localparam logic [1:0] F_ILL   = 2'd1;
    localparam logic [1:0] F_BUS   = 2'd2;

    // Counter value seen on the last MEM cycle allowed before timeout.
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    state_t     state_nx;
    logic       run;
    logic [7:0] tcnt;
    logic [3:0] op;

    logic       ir_ld;
    logic       retire;
    logic [1:0] fault_set;
    logic       tcnt_inc;
    logic       tcnt_clr;

    logic is_nop;
    logic is_alu;
    logic is_ldi;
    logic is_ld;
    logic is_st;
    logic is_beq;
    logic is_jmp;
    logic is_halt;
    logic is_ill;

    assign op        = ir[15:12];
    assign state_dbg = state;

    always_comb begin
        is_nop  = 1'b0;
        is_alu  = 1'b0;
        is_ldi  = 1'b0;
        is_ld   = 1'b0;
        is_st   = 1'b0;
        is_beq  = 1'b0;
        is_jmp  = 1'b0;
        is_halt = 1'b0;
        is_ill  = 1'b0;
        unique case (1'b1)
            op == OP_NOP:                 is_nop  = 1'b1;
            op inside {[OP_ADD:OP_XOR]}:  is_alu  = 1'b1;
            op == OP_LDI:                 is_ldi  = 1'b1;
            op == OP_LD:                  is_ld   = 1'b1;
            op == OP_ST:                  is_st   = 1'b1;
            op == OP_BEQ:                 is_beq  = 1'b1;
            op == OP_JMP:                 is_jmp  = 1'b1;
            op == OP_HALT:                is_halt = 1'b1;
            default:                      is_ill  = 1'b1;
        endcase
    end

    always_comb begin
        state_nx     = state;
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        alu_op       = 3'd0;
        rf_we        = 1'b0;
        rf_wsel      = WB_ALU;
        halted       = 1'b0;
        ir_ld        = 1'b0;
        retire       = 1'b0;
        fault_set    = 2'd0;
        tcnt_inc     = 1'b0;
        tcnt_clr     = 1'b0;
        // run gates everything for the cycle after reset release
        if (run) begin
            unique case (state)
                S_FETCH: begin
                    bus.imem_req = 1'b1;
                    if (bus.imem_ready) begin
                        ir_ld    = 1'b1;
                        state_nx = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_ill) begin
                        fault_set = F_ILL;
                        state_nx  = S_HALT;
                    end else if (is_halt) begin
                        retire   = 1'b1;
                        state_nx = S_HALT;
                    end else begin
                        state_nx = S_EXEC;
                    end
                end
                S_EXEC: begin
                    unique case (1'b1)
                        is_alu: begin
                            alu_op   = 3'(op - 4'd1);
                            state_nx = S_WB;
                        end
                        is_ldi: state_nx = S_WB;
                        is_ld || is_st: state_nx = S_MEM;
                        is_nop: begin
                            pc_inc   = 1'b1;
                            retire   = 1'b1;
                            state_nx = S_FETCH;
                        end
                        is_jmp: begin
                            pc_load  = 1'b1;
                            retire   = 1'b1;
                            state_nx = S_FETCH;
                        end
                        is_beq: begin
                            alu_op   = ALU_SUB;
                            pc_load  = zero_flag;
                            pc_inc   = ~zero_flag;
                            retire   = 1'b1;
                            state_nx = S_FETCH;
                        end
                        default: state_nx = S_HALT;
                    endcase
                end
                S_MEM: begin
                    bus.dmem_req = 1'b1;
                    bus.dmem_we  = is_st;
                    if (bus.dmem_ready) begin
                        tcnt_clr = 1'b1;
                        if (is_st) begin
                            pc_inc   = 1'b1;
                            retire   = 1'b1;
                            state_nx = S_FETCH;
                        end else begin
                            state_nx = S_WB;
                        end
                    end else if (tcnt == TO_LAST) begin
                        tcnt_clr  = 1'b1;
                        fault_set = F_BUS;
                        state_nx  = S_HALT;
                    end else begin
                        tcnt_inc = 1'b1;
                    end
                end
                S_WB: begin
                    rf_we    = 1'b1;
                    pc_inc   = 1'b1;
                    retire   = 1'b1;
                    rf_wsel  = is_ldi ? WB_IMM : (is_ld ? WB_MEM : WB_ALU);
                    state_nx = S_FETCH;
                end
                S_HALT: halted = 1'b1;
                default: state_nx = S_HALT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
            run   <= 1'b0;
        end else begin
            state <= state_nx;
            run   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir      <= 16'h0000;
            fault   <= 2'd0;
            retired <= '0;
            tcnt    <= 8'd0;
        end else begin
            if (ir_ld)
                ir <= bus.instr;
            if (fault_set != 2'd0)
                fault <= fault_set;
            if (retire)
                retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
            if (tcnt_clr)
                tcnt <= 8'd0;
            else if (tcnt_inc)
                tcnt <= tcnt + 8'd1;
        end
    end

    a_pc_excl: assert property (@(posedge clk) disable iff (!reset)
        !(pc_inc && pc_load));

    a_halt_quiet: assert property (@(posedge clk) disable iff (!reset)
        halted |-> !(pc_inc || pc_load || rf_we || bus.dmem_req || bus.imem_req));

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Scoreboard bench for cpu_ctrl_seq: driver pushes per-instruction
// expectations, a negedge monitor pops them when an instruction completes.
module tb_cpu_ctrl_seq;
    localparam int TO = 15;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   ir;
    logic          pc_inc, pc_load, rf_we, zero_flag, halted;
    logic [2:0]    alu_op, state_dbg;
    logic [1:0]    rf_wsel, fault;
    logic [CW-1:0] retired;

    always #5 clk = ~clk;

    cpu_ctrl_seq_if bus();

    cpu_ctrl_seq #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .ir(ir), .pc_inc(pc_inc), .pc_load(pc_load),
        .alu_op(alu_op), .rf_we(rf_we), .rf_wsel(rf_wsel),
        .zero_flag(zero_flag), .halted(halted), .fault(fault),
        .state_dbg(state_dbg), .retired(retired)
    );

    typedef struct {
        logic [15:0] ins;
        int          freq;
        int          lat;
        bit          pinc, pload, we;
        logic [1:0]  wsel;
        logic [2:0]  alu;
        int          dcyc;
        bit          dwe;
        bit          halt;
        logic [1:0]  flt;
        int          ret;
    } exp_t;

    exp_t sbq[$];
    exp_t mexp;
    int   checks = 0;
    int   errors = 0;
    int   model_ret = 0;
    int   dwait = 0;
    bit   force_rdy = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", nm);
    endtask

    // Expected outcome of one instruction, from the ISA rules alone.
    function automatic exp_t model(logic [15:0] ins, int iw, bit zf, int dw, int r);
        exp_t e;
        int op;
        op = int'(ins[15:12]);
        e.ins = ins; e.freq = iw + 1; e.lat = 3;
        e.pinc = 0; e.pload = 0; e.we = 0; e.wsel = 2'd0; e.alu = 3'd0;
        e.dcyc = 0; e.dwe = 0; e.halt = 0; e.flt = 2'd0;
        e.ret = r % (1 << CW);
        if (op >= 1 && op <= 5) begin
            e.lat = 4; e.pinc = 1; e.we = 1; e.alu = 3'(op - 1);
        end else if (op == 0) begin
            e.pinc = 1;
        end else if (op == 6) begin
            e.lat = 4; e.pinc = 1; e.we = 1; e.wsel = 2'd1;
        end else if (op == 7 || op == 8) begin
            e.dwe = (op == 8);
            if (dw < TO) begin
                e.dcyc = dw + 1;
                e.pinc = 1;
                if (op == 7) begin
                    e.lat = 5 + dw; e.we = 1; e.wsel = 2'd2;
                end else begin
                    e.lat = 4 + dw;
                end
            end else begin
                e.lat = 4 + TO; e.dcyc = TO; e.halt = 1; e.flt = 2'd2;
            end
        end else if (op == 9) begin
            e.alu = 3'd1; e.pload = zf; e.pinc = !zf;
        end else if (op == 10) begin
            e.pload = 1;
        end else if (op == 15) begin
            e.halt = 1; e.ret = (r + 1) % (1 << CW);
        end else begin
            e.halt = 1; e.flt = 2'd1;
        end
        return e;
    endfunction

    // Monitor
    int       cyc = 0, rq = 0, dc = 0;
    bit       infl = 0, dwseen = 0;
    logic [2:0] al = 3'd0;

    always @(negedge clk) begin
        if (!reset) begin
            infl = 0;
            rq = 0;
        end else begin
            if (infl) cyc++;
            if (!infl && bus.imem_req) begin
                rq++;
                if (bus.imem_ready) begin
                    infl = 1; cyc = 1; dc = 0; dwseen = 0; al = 3'd0;
                end
            end
            if (infl) begin
                if (state_dbg == 3'd2) al = alu_op;
                if (bus.dmem_req) begin
                    dc++;
                    dwseen = dwseen | bus.dmem_we;
                end
                if (pc_inc || pc_load || halted) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_completion", 32'(sbq.size()), 32'd1);
                    end else begin
                        mexp = sbq.pop_front();
                        chk("ir", ir, mexp.ins);
                        chk("latency", cyc, mexp.lat);
                        chk("fetch_req_cycles", rq, mexp.freq);
                        chk("pc_inc", pc_inc, mexp.pinc);
                        chk("pc_load", pc_load, mexp.pload);
                        chk("rf_we", rf_we, mexp.we);
                        chk("rf_wsel", rf_wsel, mexp.wsel);
                        chk("alu_op", al, mexp.alu);
                        chk("dmem_req_cycles", dc, mexp.dcyc);
                        chk("dmem_we", dwseen, mexp.dwe);
                        chk("halted", halted, mexp.halt);
                        chk("fault", fault, mexp.flt);
                        chk("retired", retired, mexp.ret);
                    end
                    infl = 0;
                    rq = 0;
                end else begin
                    chk("stray_rf_we", rf_we, 1'b0);
                end
            end
        end
    end

    // Data-memory responder: ready after dwait wait cycles in MEM.
    int mc = 0;
    initial begin
        bus.dmem_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!reset || !bus.dmem_req) begin
                mc = 0;
                bus.dmem_ready = force_rdy;
            end else begin
                bus.dmem_ready = force_rdy || (mc == dwait);
                mc++;
            end
        end
    end

    task automatic issue(logic [15:0] ins, int iw, bit zf, int dw);
        exp_t e;
        int n;
        n = 0;
        while (1) begin
            @(posedge clk); #1;
            if (bus.imem_req) break;
            n++;
            if (n > 300) begin
                timeout_fail("fetch_wait");
                return;
            end
        end
        zero_flag = zf;
        dwait = dw;
        e = model(ins, iw, zf, dw, model_ret);
        sbq.push_back(e);
        if (!(e.halt && e.flt != 2'd0)) model_ret++;
        repeat (iw) begin
            bus.instr = 16'($urandom);
            @(posedge clk); #1;
        end
        bus.imem_ready = 1'b1;
        bus.instr = ins;
        @(posedge clk); #1;
        bus.imem_ready = 1'b0;
        bus.instr = 16'($urandom);
    endtask

    task automatic check_quiet(string tag);
        chk({tag, "_state"}, state_dbg, 3'd0);
        chk({tag, "_ir"}, ir, 16'h0);
        chk({tag, "_retired"}, retired, '0);
        chk({tag, "_fault"}, fault, 2'd0);
        chk({tag, "_strobes"},
            {bus.imem_req, bus.dmem_req, bus.dmem_we, pc_inc, pc_load, rf_we, halted},
            7'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_quiet("reset");
        sbq.delete();
        model_ret = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic wait_halt(logic [1:0] fexp);
        int n;
        n = 0;
        while (!halted) begin
            @(posedge clk); #1;
            n++;
            if (n > 100) begin
                timeout_fail("halt_wait");
                return;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        force_rdy = 1'b1;
        bus.imem_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("hold_halted", halted, 1'b1);
        chk("hold_state", state_dbg, 3'd5);
        chk("hold_fault", fault, fexp);
        chk("hold_reqs", {bus.imem_req, bus.dmem_req}, 2'b00);
        chk("hold_retired", retired, CW'(model_ret % (1 << CW)));
        force_rdy = 1'b0;
        bus.imem_ready = 1'b0;
    endtask

    initial begin
        int op, dw, iw, n;
        reset = 1'b0;
        zero_flag = 1'b0;
        bus.imem_ready = 1'b1;
        bus.instr = 16'h1298;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("init");
        bus.imem_ready = 1'b0;
        reset = 1'b1;

        issue(16'h1298, 0, 1'b0, 0);
        issue(16'h6A2A, 3, 1'b0, 0);
        issue(16'h9005, 0, 1'b1, 0);
        issue(16'h9005, 1, 1'b0, 0);
        issue(16'h7200, 0, 1'b0, 2);
        issue(16'h8123, 0, 1'b0, 14);
        issue(16'hA0FF, 0, 1'b0, 0);
        issue(16'h0000, 2, 1'b0, 0);
        issue(16'h7E00, 0, 1'b0, 0);
        issue(16'h4A58, 0, 1'b0, 0);

        for (int k = 0; k < 40; k++) begin
            op = $urandom_range(0, 10);
            dw = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 3);
            iw = $urandom_range(0, 3);
            issue({4'(op), 12'($urandom)}, iw, 1'($urandom), dw);
        end

        issue(16'h8000, 0, 1'b0, 99);
        wait_halt(2'd2);
        do_reset();

        issue(16'hB000, 0, 1'b0, 0);
        wait_halt(2'd1);
        do_reset();

        issue(16'hF000, 1, 1'b0, 0);
        wait_halt(2'd0);
        do_reset();

        op = $urandom_range(11, 14);
        issue({4'(op), 12'($urandom)}, 0, 1'b0, 0);
        wait_halt(2'd1);
        do_reset();

        issue(16'h1298, 0, 1'b0, 0);
        issue(16'h7200, 0, 1'b0, 99);
        n = 0;
        while (n < 3) begin
            @(posedge clk); #1;
            if (bus.dmem_req) n++;
            else if (state_dbg == 3'd5) begin
                timeout_fail("mid_mem_wait");
                n = 3;
            end
        end
        do_reset();

        issue(16'h3E38, 0, 1'b0, 0);
        issue(16'h9005, 0, 1'b1, 0);

        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("queue_drain", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
